// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and geometry for the cache refill/invalidate sequencer.
// Entry layout is {valid, tag, data}, with valid in the MSB.
package cache_pkg;

    localparam int IDX_W   = 10;
    localparam int TAG_W   = 18;
    localparam int OFF_W   = 4;
    localparam int LINE_W  = 128;
    localparam int ENTRY_W = 1 + TAG_W + LINE_W;
    localparam int ADDR_W  = TAG_W + IDX_W + OFF_W;
    localparam int LADDR_W = TAG_W + IDX_W;

    typedef enum logic [2:0] {
        SWEEP = 3'd0,
        IDLE  = 3'd1,
        MREQ  = 3'd2,
        MWAIT = 3'd3,
        FILL  = 3'd4,
        ACK   = 3'd5
    } state_t;

    typedef enum logic {
        DATA = 1'b0,
        INST = 1'b1
    } side_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } cache_entry_t;

endpackage

// File: rtl/cache_fill_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; last_grant only moves when the
// grant is actually taken (upd_en), so a flush does not disturb fairness.
module rr_arb2
    import cache_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  d_req,
    input  logic  i_req,
    input  logic  upd_en,
    output logic  gnt_valid,
    output side_t gnt_side
);

    side_t last_grant;

    always_comb begin
        gnt_valid = d_req | i_req;
        if (d_req && i_req) begin
            gnt_side = (last_grant == DATA) ? INST : DATA;
        end else if (i_req) begin
            gnt_side = INST;
        end else begin
            gnt_side = DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= INST;
        end else if (upd_en && gnt_valid) begin
            last_grant <= gnt_side;
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Refill and invalidate sequencer for the shared data/instruction cache BRAM.
// Outputs decode the registered state so the sweep writes index 0 in the first cycle out of reset.
//
//   state | meaning
//   SWEEP | write an invalid entry at cnt on the data port, cnt++
//   IDLE  | accept flush (highest priority) or arbitrate a miss
//   MREQ  | mem_req held with the latched line address until mem_ack
//   MWAIT | wait for mem_rvalid, capture the line
//   FILL  | write {1, tag, data} through the granted side's port
//   ACK   | pulse the granted side's ack
module cache_fill_ctrl
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               d_req,
    input  logic [ADDR_W-1:0]  d_addr,
    output logic               d_ack,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic               i_ack,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               busy,
    output logic               mem_req,
    output logic [LADDR_W-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic               mem_rvalid,
    input  logic [LINE_W-1:0]  mem_rdata,
    output logic               d_fill_we,
    output logic               i_fill_we,
    output logic [IDX_W-1:0]   fill_idx,
    output logic [ENTRY_W-1:0] fill_line
);

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [IDX_W-1:0]  lat_idx;
    logic [TAG_W-1:0]  lat_tag;
    logic [LINE_W-1:0] lat_data;
    side_t             lat_side;
    logic              done_pend;

    logic              gnt_valid;
    side_t             gnt_side;
    logic              arb_upd;
    logic [ADDR_W-1:0] sel_addr;
    cache_entry_t      fill_entry;
    logic              unused_off;

    assign unused_off = ^{d_addr[OFF_W-1:0], i_addr[OFF_W-1:0]};
    assign arb_upd    = (state == IDLE) && !flush_req;
    assign sel_addr   = (gnt_side == INST) ? i_addr : d_addr;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .d_req     (d_req),
        .i_req     (i_req),
        .upd_en    (arb_upd),
        .gnt_valid (gnt_valid),
        .gnt_side  (gnt_side)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SWEEP;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_tag   <= '0;
            lat_data  <= '0;
            lat_side  <= DATA;
            done_pend <= 1'b0;
        end else begin
            done_pend <= 1'b0;
            case (state)
                SWEEP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state     <= IDLE;
                        done_pend <= 1'b1;
                    end
                end
                IDLE: begin
                    if (flush_req) begin
                        state <= SWEEP;
                        cnt   <= '0;
                    end else if (gnt_valid) begin
                        lat_side <= gnt_side;
                        lat_idx  <= sel_addr[OFF_W +: IDX_W];
                        lat_tag  <= sel_addr[OFF_W+IDX_W +: TAG_W];
                        state    <= MREQ;
                    end
                end
                MREQ: begin
                    if (mem_ack) state <= MWAIT;
                end
                MWAIT: begin
                    if (mem_rvalid) begin
                        lat_data <= mem_rdata;
                        state    <= FILL;
                    end
                end
                FILL:    state <= ACK;
                ACK:     state <= IDLE;
                default: state <= SWEEP;
            endcase
        end
    end

    always_comb begin
        fill_entry.valid = 1'b1;
        fill_entry.tag   = lat_tag;
        fill_entry.data  = lat_data;
    end

    // Every output is forced low while rst is held, even though state already reads SWEEP.
    always_comb begin
        busy       = 1'b0;
        flush_done = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        d_fill_we  = 1'b0;
        i_fill_we  = 1'b0;
        fill_idx   = '0;
        fill_line  = '0;
        d_ack      = 1'b0;
        i_ack      = 1'b0;
        if (!rst) begin
            busy       = (state != IDLE);
            flush_done = done_pend;
            case (state)
                SWEEP: begin
                    d_fill_we = 1'b1;
                    fill_idx  = cnt;
                end
                MREQ: begin
                    mem_req  = 1'b1;
                    mem_addr = {lat_tag, lat_idx};
                end
                FILL: begin
                    d_fill_we = (lat_side == DATA);
                    i_fill_we = (lat_side == INST);
                    fill_idx  = lat_idx;
                    fill_line = fill_entry;
                end
                ACK: begin
                    d_ack = (lat_side == DATA);
                    i_ack = (lat_side == INST);
                end
                default: ;
            endcase
        end
    end

    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (state inside {MREQ, MWAIT, FILL}) |-> ((lat_side == DATA) ? d_req : i_req));

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: sweeps, single and arbitrated misses,
// flush priority, stalled mem_ack and reset in the middle of a miss.
module tb_cache_fill_ctrl;
    import cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         d_req = 1'b0;
    logic         i_req = 1'b0;
    logic         flush_req = 1'b0;
    logic         mem_ack = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [31:0]  d_addr = '0;
    logic [31:0]  i_addr = '0;
    logic [127:0] mem_rdata = '0;

    logic         d_ack, i_ack, flush_done, busy, mem_req;
    logic [27:0]  mem_addr;
    logic         d_fill_we, i_fill_we;
    logic [9:0]   fill_idx;
    logic [146:0] fill_line;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_fill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_ack      (d_ack),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ack      (i_ack),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .d_fill_we  (d_fill_we),
        .i_fill_we  (i_fill_we),
        .fill_idx   (fill_idx),
        .fill_line  (fill_line)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // Expects the current cycle to be sweep write 0; ends in the flush_done cycle.
    task automatic sweep_check(input string tag, input int rv_at);
        int bad;
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            if (k == rv_at) begin
                mem_rvalid = 1'b1;
                mem_rdata  = {4{32'hDEADBEEF}};
            end else begin
                mem_rvalid = 1'b0;
            end
            if (!(d_fill_we === 1'b1 && fill_idx === 10'(k) && fill_line === '0 &&
                  i_fill_we === 1'b0 && busy === 1'b1 && mem_req === 1'b0 &&
                  d_ack === 1'b0 && i_ack === 1'b0 && flush_done === 1'b0))
                bad++;
            step();
        end
        mem_rvalid = 1'b0;
        check_eq({tag, "_bad_cycles"}, 160'(bad), 160'(0));
        check_eq({tag, "_flush_done"}, 160'(flush_done), 160'(1));
        check_eq({tag, "_idle_no_we"}, 160'({busy, d_fill_we, i_fill_we}), 160'(0));
    endtask

    // Serves one miss from mem_req through ACK; ends in the cycle after ACK.
    task automatic do_txn(input string tag, input side_t side, input logic [31:0] addr,
                          input logic [127:0] data, input int ack_wait);
        int n;
        int bad;
        logic [27:0]  exp_ma;
        logic [146:0] exp_line;
        n = 0;
        bad = 0;
        exp_ma   = addr[31:4];
        exp_line = {1'b1, addr[31:14], data};
        while (mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (mem_req !== 1'b1) begin
            check_eq({tag, "_mem_req_timeout"}, 160'(mem_req), 160'(1));
            return;
        end
        check_eq({tag, "_mem_addr"}, 160'(mem_addr), 160'(exp_ma));
        for (int w = 0; w < ack_wait; w++) begin
            if (mem_req !== 1'b1 || mem_addr !== exp_ma) bad++;
            step();
        end
        check_eq({tag, "_req_hold"}, 160'({bad[7:0], mem_req}), 160'({8'd0, 1'b1}));
        mem_ack = 1'b1;
        step();
        mem_ack    = 1'b0;
        check_eq({tag, "_req_drop"}, 160'({mem_req, busy}), 160'({1'b0, 1'b1}));
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        step();
        mem_rvalid = 1'b0;
        check_eq({tag, "_fill_we"}, 160'({d_fill_we, i_fill_we}),
                 160'((side == DATA) ? 2'b10 : 2'b01));
        check_eq({tag, "_fill_idx"}, 160'(fill_idx), 160'(addr[13:4]));
        check_eq({tag, "_fill_line"}, 160'(fill_line), 160'(exp_line));
        check_eq({tag, "_no_early_ack"}, 160'({d_ack, i_ack}), 160'(0));
        step();
        check_eq({tag, "_ack"}, 160'({d_ack, i_ack}), 160'((side == DATA) ? 2'b10 : 2'b01));
        check_eq({tag, "_ack_quiet"}, 160'({d_fill_we, i_fill_we, fill_idx, fill_line}), 160'(0));
        if (side == DATA) d_req = 1'b0;
        else              i_req = 1'b0;
        step();
        check_eq({tag, "_after_ack"}, 160'({d_ack, i_ack}), 160'(0));
    endtask

    initial begin
        // Reset and initial sweep.
        repeat (3) step();
        check_eq("rst_outputs", 160'({busy, d_fill_we, i_fill_we, mem_req, d_ack, i_ack, flush_done,
                                       fill_idx, fill_line, mem_addr}), 160'(0));
        rst = 1'b0;
        #1;
        sweep_check("init_sweep", -1);
        step();
        check_eq("init_done_pulse", 160'({flush_done, busy}), 160'(0));

        // Simultaneous requests twice: DATA, INST, DATA, INST.
        d_addr = 32'h0000_1230; i_addr = 32'hFFFF_C010;
        d_req = 1'b1; i_req = 1'b1;
        do_txn("rr1_d", DATA, 32'h0000_1230, {4{32'h1111_0001}}, 0);
        do_txn("rr1_i", INST, 32'hFFFF_C010, {4{32'h2222_0002}}, 0);
        d_addr = 32'h8000_3FF0; i_addr = 32'h0ABC_D000;
        d_req = 1'b1; i_req = 1'b1;
        do_txn("rr2_d", DATA, 32'h8000_3FF0, {4{32'h3333_0003}}, 0);
        do_txn("rr2_i", INST, 32'h0ABC_D000, {4{32'h4444_0004}}, 0);

        // Single data miss at minimum latency.
        d_addr = 32'h1234_5670;
        d_req  = 1'b1;
        step();
        check_eq("dmiss_req_latency", 160'(mem_req), 160'(1));
        check_eq("dmiss_mem_addr_exact", 160'(mem_addr), 160'(28'h1234567));
        do_txn("dmiss", DATA, 32'h1234_5670, {16{8'hA5}}, 0);

        // Flush beats a simultaneous instruction miss.
        i_addr    = 32'h4444_5550;
        flush_req = 1'b1;
        i_req     = 1'b1;
        step();
        flush_req = 1'b0;
        check_eq("flush_no_mem_req", 160'(mem_req), 160'(0));
        sweep_check("flush_sweep", -1);
        do_txn("flush_imiss", INST, 32'h4444_5550, {4{32'h5555_0005}}, 0);

        // mem_ack withheld for 5 cycles.
        d_addr = 32'h0F0F_0F00;
        d_req  = 1'b1;
        do_txn("stall", DATA, 32'h0F0F_0F00, {4{32'h6666_0006}}, 5);

        // Reset during MWAIT, orphan rvalid 2 cycles after release.
        d_addr = 32'h2222_2220;
        d_req  = 1'b1;
        for (int n = 0; n < 20 && mem_req !== 1'b1; n++) step();
        check_eq("rst_mid_mem_req", 160'(mem_req), 160'(1));
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check_eq("rst_mid_mwait", 160'({mem_req, busy}), 160'({1'b0, 1'b1}));
        rst   = 1'b1;
        d_req = 1'b0;
        #1;
        check_eq("rst_mid_outputs", 160'({busy, mem_req, d_fill_we, i_fill_we, d_ack, i_ack}), 160'(0));
        step();
        step();
        rst = 1'b0;
        #1;
        sweep_check("rst_sweep", 2);
        step();
        check_eq("rst_sweep_no_ack", 160'({d_ack, i_ack, flush_done, busy, d_fill_we, i_fill_we}), 160'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
